// File: rtl/cache_tag_controller_if.sv
// Request/response, policy and block-fill signals of the tag-lookup stage.
// Directions in the signal names are as seen from the tag controller.
interface cache_tag_controller_if #(
   parameter int unsigned BW_ACCESS_ADDR     = 16,
   parameter int unsigned BW_CAPACITY_BLOCKS = 3
);
   logic                          req_i;
   logic [BW_ACCESS_ADDR-1:0]     req_addr_i;
   logic                          ready_o;
   logic                          policy_miss_o;
   logic                          policy_hit_o;
   logic [BW_ACCESS_ADDR-1:0]     policy_access_addr_o;
   logic [BW_CAPACITY_BLOCKS-1:0] policy_cache_addr_o;
   logic                          policy_done_i;
   logic [BW_CAPACITY_BLOCKS-1:0] policy_addr_i;
   logic                          fill_req_o;
   logic [BW_ACCESS_ADDR-1:0]     fill_mem_addr_o;
   logic [BW_CAPACITY_BLOCKS-1:0] fill_cache_addr_o;
   logic                          fill_done_i;
   logic                          resp_valid_o;
   logic                          resp_hit_o;
   logic [BW_CAPACITY_BLOCKS-1:0] resp_cache_addr_o;

   modport slave (
      input  req_i, req_addr_i, policy_done_i, policy_addr_i, fill_done_i,
      output ready_o, policy_miss_o, policy_hit_o, policy_access_addr_o, policy_cache_addr_o,
             fill_req_o, fill_mem_addr_o, fill_cache_addr_o,
             resp_valid_o, resp_hit_o, resp_cache_addr_o
   );

   modport master (
      output req_i, req_addr_i, policy_done_i, policy_addr_i, fill_done_i,
      input  ready_o, policy_miss_o, policy_hit_o, policy_access_addr_o, policy_cache_addr_o,
             fill_req_o, fill_mem_addr_o, fill_cache_addr_o,
             resp_valid_o, resp_hit_o, resp_cache_addr_o
   );
endinterface

// File: rtl/cache_tag_controller.sv
// Tag lookup and miss sequencing in front of the replacement-policy controller:
// hit/miss detection, victim capture, block-fill handshake and tag rewrite.
module cache_tag_controller #(
   parameter int unsigned BW_ACCESS_ADDR    = 16,
   parameter int unsigned N_CAPACITY_BLOCKS = 8,
   parameter int unsigned N_WORDS_PER_BLOCK = 4,
   parameter int unsigned ASSOCIATIVITY     = 2
) (
   input  logic                   clock_i,
   input  logic                   resetn_i,
   cache_tag_controller_if.slave  bus
);
   localparam int unsigned N_SETS   = N_CAPACITY_BLOCKS / ASSOCIATIVITY;
   localparam int unsigned BW_WORDS = $clog2(N_WORDS_PER_BLOCK);
   localparam int unsigned BW_SET   = $clog2(N_SETS);
   localparam int unsigned BW_WAY   = $clog2(ASSOCIATIVITY);
   localparam int unsigned BW_CAP   = $clog2(N_CAPACITY_BLOCKS);
   localparam int unsigned BW_TAG   = BW_ACCESS_ADDR - BW_WORDS - BW_SET;
   // Zero-width fields are carried as one constant-zero bit.
   localparam int unsigned SET_W    = (BW_SET > 0) ? BW_SET : 1;
   localparam int unsigned WAY_W    = (BW_WAY > 0) ? BW_WAY : 1;
   localparam logic [BW_ACCESS_ADDR-1:0] WORD_MASK = BW_ACCESS_ADDR'(N_WORDS_PER_BLOCK - 1);

   typedef enum logic [2:0] {
      StIdle, StLookup, StMissPulse, StMissSample, StFill, StRespond
   } state_e;

   state_e                    state_q, state_d;
   logic [BW_ACCESS_ADDR-1:0] req_addr_q;
   logic                      hit_q;
   logic [WAY_W-1:0]          hit_way_q;
   logic [BW_CAP-1:0]         victim_q;
   logic [N_CAPACITY_BLOCKS-1:0] valid_q;
   logic [BW_TAG-1:0]         tag_q [N_CAPACITY_BLOCKS];

   logic [SET_W-1:0]  req_set;
   logic [BW_TAG-1:0] req_tag;
   logic              lookup_hit;
   logic [WAY_W-1:0]  lookup_way;
   logic [WAY_W-1:0]  victim_way;
   logic [BW_CAP-1:0] fill_idx;
   logic [BW_CAP-1:0] hit_blk;
   logic              fill_wr;

   function automatic logic [BW_CAP-1:0] blk_addr(input logic [WAY_W-1:0] way,
                                                  input logic [SET_W-1:0] set);
      logic [BW_CAP-1:0] b;
      b = BW_CAP'(way) << BW_SET;
      if (BW_SET > 0) b = b | BW_CAP'(set);
      return b;
   endfunction

   assign req_set    = (BW_SET > 0) ? SET_W'(req_addr_q >> BW_WORDS) : '0;
   assign req_tag    = BW_TAG'(req_addr_q >> (BW_WORDS + BW_SET));
   assign victim_way = WAY_W'(victim_q >> BW_SET);
   // The victim's set bits are trusted to match the request; the request set is used.
   assign fill_idx   = blk_addr(victim_way, req_set);
   assign hit_blk    = blk_addr(hit_way_q, req_set);
   assign fill_wr    = (state_q == StFill) && bus.fill_done_i;

   // Ascending scan taking only the first match, so the lowest way wins.
   always_comb begin
      lookup_hit = 1'b0;
      lookup_way = '0;
      for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
         if (!lookup_hit && valid_q[blk_addr(WAY_W'(w), req_set)] &&
             tag_q[blk_addr(WAY_W'(w), req_set)] == req_tag) begin
            lookup_hit = 1'b1;
            lookup_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      bus.ready_o       = 1'b0;
      bus.policy_miss_o = 1'b0;
      bus.policy_hit_o  = 1'b0;
      bus.fill_req_o    = 1'b0;
      bus.resp_valid_o  = 1'b0;
      bus.resp_hit_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.ready_o = 1'b1;
            if (bus.req_i) state_d = StLookup;
         end
         StLookup:    state_d = lookup_hit ? StRespond : StMissPulse;
         StMissPulse: begin
            bus.policy_miss_o = 1'b1;
            state_d           = StMissSample;
         end
         StMissSample: if (bus.policy_done_i) state_d = StFill;
         StFill: begin
            bus.fill_req_o = 1'b1;
            if (bus.fill_done_i) state_d = StRespond;
         end
         StRespond: begin
            bus.resp_valid_o = 1'b1;
            bus.resp_hit_o   = hit_q;
            bus.policy_hit_o = hit_q;
            state_d          = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Strobes fall as soon as reset is asserted, ahead of the state register.
      if (!resetn_i) begin
         bus.ready_o       = 1'b0;
         bus.policy_miss_o = 1'b0;
         bus.policy_hit_o  = 1'b0;
         bus.fill_req_o    = 1'b0;
         bus.resp_valid_o  = 1'b0;
         bus.resp_hit_o    = 1'b0;
      end
   end

   assign bus.policy_access_addr_o = req_addr_q;
   assign bus.policy_cache_addr_o  = hit_blk;
   assign bus.fill_mem_addr_o      = req_addr_q & ~WORD_MASK;
   assign bus.fill_cache_addr_o    = victim_q;
   assign bus.resp_cache_addr_o    = hit_q ? hit_blk : victim_q;

   always_ff @(posedge clock_i) begin
      if (!resetn_i) begin
         state_q    <= StIdle;
         req_addr_q <= '0;
         hit_q      <= 1'b0;
         hit_way_q  <= '0;
         victim_q   <= '0;
         valid_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && bus.req_i) req_addr_q <= bus.req_addr_i;
         if (state_q == StLookup) begin
            hit_q     <= lookup_hit;
            hit_way_q <= lookup_way;
         end
         if (state_q == StMissSample && bus.policy_done_i) victim_q <= bus.policy_addr_i;
         if (fill_wr) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag contents are meaningless until the valid bit is set, so no reset.
   always_ff @(posedge clock_i) begin
      if (fill_wr) tag_q[fill_idx] <= req_tag;
   end
endmodule

// File: tb/tb_cache_tag_controller.sv
// Directed bench for cache_tag_controller: a block-level cache model predicts a
// per-cycle output schedule that one negedge process compares against the DUT.
module tb_cache_tag_controller;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetn;
   bit          sel;      // 0: 2-way set-assoc DUT, 1: fully associative DUT
   logic        req;
   logic [15:0] addr;
   logic        pdone;
   logic [2:0]  paddr;
   logic        fdone;
   bit          armed;

   cache_tag_controller_if #(.BW_ACCESS_ADDR(16), .BW_CAPACITY_BLOCKS(3)) bus_a ();
   cache_tag_controller_if #(.BW_ACCESS_ADDR(16), .BW_CAPACITY_BLOCKS(2)) bus_f ();

   assign bus_a.req_i         = req & ~sel;
   assign bus_a.req_addr_i    = addr;
   assign bus_a.policy_done_i = pdone & ~sel;
   assign bus_a.policy_addr_i = paddr;
   assign bus_a.fill_done_i   = fdone & ~sel;
   assign bus_f.req_i         = req & sel;
   assign bus_f.req_addr_i    = addr;
   assign bus_f.policy_done_i = pdone & sel;
   assign bus_f.policy_addr_i = paddr[1:0];
   assign bus_f.fill_done_i   = fdone & sel;

   cache_tag_controller #(
      .BW_ACCESS_ADDR(16), .N_CAPACITY_BLOCKS(8), .N_WORDS_PER_BLOCK(4), .ASSOCIATIVITY(2)
   ) dut_a (
      .clock_i(clock), .resetn_i(resetn), .bus(bus_a)
   );

   cache_tag_controller #(
      .BW_ACCESS_ADDR(16), .N_CAPACITY_BLOCKS(4), .N_WORDS_PER_BLOCK(4), .ASSOCIATIVITY(4)
   ) dut_f (
      .clock_i(clock), .resetn_i(resetn), .bus(bus_f)
   );

   logic        o_ready, o_miss, o_hit, o_fill, o_resp, o_resp_hit;
   logic [15:0] o_pacc, o_fmem;
   logic [2:0]  o_pblk, o_fblk, o_rblk;

   always_comb begin
      if (sel) begin
         o_ready = bus_f.ready_o;      o_miss = bus_f.policy_miss_o;
         o_hit = bus_f.policy_hit_o;   o_fill = bus_f.fill_req_o;
         o_resp = bus_f.resp_valid_o;  o_resp_hit = bus_f.resp_hit_o;
         o_pacc = bus_f.policy_access_addr_o;  o_fmem = bus_f.fill_mem_addr_o;
         o_pblk = {1'b0, bus_f.policy_cache_addr_o};
         o_fblk = {1'b0, bus_f.fill_cache_addr_o};
         o_rblk = {1'b0, bus_f.resp_cache_addr_o};
      end else begin
         o_ready = bus_a.ready_o;      o_miss = bus_a.policy_miss_o;
         o_hit = bus_a.policy_hit_o;   o_fill = bus_a.fill_req_o;
         o_resp = bus_a.resp_valid_o;  o_resp_hit = bus_a.resp_hit_o;
         o_pacc = bus_a.policy_access_addr_o;  o_fmem = bus_a.fill_mem_addr_o;
         o_pblk = bus_a.policy_cache_addr_o;
         o_fblk = bus_a.fill_cache_addr_o;
         o_rblk = bus_a.resp_cache_addr_o;
      end
   end

   typedef struct packed {
      bit        ready, miss, hit, fill, resp, resp_hit;
      bit [15:0] acc, fmem;
      bit [2:0]  pblk, fblk, rblk;
   } exp_t;

   exp_t  expq[$];
   string lit_n[$];
   int    lit_a[$];
   int    lit_e[$];

   int checks = 0;
   int errors = 0;
   int miss_cnt = 0, hit_cnt = 0, resp_cnt = 0, fill_cyc = 0;
   int last_hit = 0, last_blk = 0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (armed) begin
         if (expq.size() > 0) e = expq.pop_front();
         else begin
            e = '0;
            e.ready = 1'b1;
         end
         chk("ready_o", int'(o_ready), int'(e.ready));
         chk("policy_miss_o", int'(o_miss), int'(e.miss));
         chk("policy_hit_o", int'(o_hit), int'(e.hit));
         chk("fill_req_o", int'(o_fill), int'(e.fill));
         chk("resp_valid_o", int'(o_resp), int'(e.resp));
         if (e.hit) chk("policy_cache_addr_o", int'(o_pblk), int'(e.pblk));
         if (e.hit || e.miss) chk("policy_access_addr_o", int'(o_pacc), int'(e.acc));
         if (e.fill) begin
            chk("fill_mem_addr_o", int'(o_fmem), int'(e.fmem));
            chk("fill_cache_addr_o", int'(o_fblk), int'(e.fblk));
         end
         if (e.resp) begin
            chk("resp_hit_o", int'(o_resp_hit), int'(e.resp_hit));
            chk("resp_cache_addr_o", int'(o_rblk), int'(e.rblk));
         end
         if (o_miss) miss_cnt++;
         if (o_hit) hit_cnt++;
         if (o_fill) fill_cyc++;
         if (o_resp) begin
            resp_cnt++;
            last_hit = int'(o_resp_hit);
            last_blk = int'(o_rblk);
         end
      end
      while (lit_n.size() > 0) chk(lit_n.pop_front(), lit_a.pop_front(), lit_e.pop_front());
   end

   // Model: which memory block (addr >> 2) each cache block holds, per configuration.
   int unsigned m_blk [2][8];
   bit          m_v   [2][8];

   function automatic int lookup(input logic [15:0] a);
      int unsigned nsets, assoc, ba, s, b;
      nsets = sel ? 1 : 4;
      assoc = sel ? 4 : 2;
      ba    = 32'(a) >> 2;
      s     = ba % nsets;
      for (int unsigned w = 0; w < assoc; w++) begin
         b = w * nsets + s;
         if (m_v[int'(sel)][b] && m_blk[int'(sel)][b] == ba) return int'(b);
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic lit(input string n, input int act, input int exp);
      lit_n.push_back(n);
      lit_a.push_back(act);
      lit_e.push_back(exp);
   endtask

   task automatic idle(input int n, input bit stray);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         fdone = stray;
         e = '0;
         e.ready = 1'b1;
         expq.push_back(e);
         tick();
      end
      fdone = 1'b0;
   endtask

   task automatic access(input logic [15:0] a, input int pol, input int fill_dly,
                         input int pd_dly, input bit hold_req, input bit rst_in_fill);
      exp_t e;
      int   hb;
      hb = lookup(a);
      req = 1'b1; addr = a;
      e = '0; e.ready = 1'b1; expq.push_back(e); tick();
      req = hold_req; addr = hold_req ? (a ^ 16'h0100) : a;
      e = '0; expq.push_back(e); tick();
      if (hb >= 0) begin
         req = 1'b0;
         e = '0; e.hit = 1'b1; e.pblk = 3'(hb); e.acc = a;
         e.resp = 1'b1; e.resp_hit = 1'b1; e.rblk = 3'(hb);
         expq.push_back(e); tick();
         return;
      end
      e = '0; e.miss = 1'b1; e.acc = a; expq.push_back(e); tick();
      for (int i = 0; i < pd_dly; i++) begin
         pdone = 1'b0; e = '0; expq.push_back(e); tick();
      end
      pdone = 1'b1; paddr = 3'(pol);
      e = '0; expq.push_back(e); tick();
      pdone = 1'b0;
      for (int i = 0; i <= fill_dly; i++) begin
         fdone = (i == fill_dly);
         e = '0; e.fill = 1'b1; e.fmem = a & 16'hfffc; e.fblk = 3'(pol);
         expq.push_back(e); tick();
         if (rst_in_fill) begin
            fdone = 1'b0; req = 1'b0; resetn = 1'b0;
            e = '0; expq.push_back(e); tick();
            resetn = 1'b1;
            for (int s = 0; s < 2; s++) for (int b = 0; b < 8; b++) m_v[s][b] = 1'b0;
            return;
         end
      end
      fdone = 1'b0; req = 1'b0;
      m_v[int'(sel)][pol] = 1'b1;
      m_blk[int'(sel)][pol] = 32'(a) >> 2;
      e = '0; e.resp = 1'b1; e.rblk = 3'(pol); expq.push_back(e); tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, f0;
      exp_t e;
      resetn = 1'b0; sel = 1'b0; req = 1'b0; addr = '0;
      pdone = 1'b0; paddr = '0; fdone = 1'b0; armed = 1'b0;
      for (int s = 0; s < 2; s++) for (int b = 0; b < 8; b++) m_v[s][b] = 1'b0;
      tick(); tick();
      armed = 1'b1;
      e = '0; expq.push_back(e); tick();   // reset held: everything low, ready_o too
      resetn = 1'b1;
      idle(2, 1'b0);

      // Cold miss in set 1; policy picks block 1; fill completes on the 4th FILL cycle.
      access(16'h0014, 1, 3, 0, 1'b0, 1'b0);
      lit("cold_miss_pulses", miss_cnt, 1);
      lit("cold_fill_cycles", fill_cyc, 4);
      lit("cold_resp_hit", last_hit, 0);
      lit("cold_resp_blk", last_blk, 1);

      // Hit in the same block, back-to-back.
      f0 = fill_cyc;
      access(16'h0017, 0, 0, 0, 1'b0, 1'b0);
      lit("hit_resp_hit", last_hit, 1);
      lit("hit_resp_blk", last_blk, 1);
      lit("hit_policy_pulses", hit_cnt, 1);
      lit("hit_no_fill", fill_cyc - f0, 0);
      idle(1, 1'b0);

      // Conflict in set 1: second fill waits one cycle for policy_done_i.
      access(16'h0114, 5, 0, 1, 1'b0, 1'b0);
      access(16'h0214, 1, 1, 0, 1'b0, 1'b0);
      access(16'h0014, 1, 0, 0, 1'b0, 1'b0);
      lit("conflict_reaccess_misses", last_hit, 0);
      access(16'h0114, 0, 0, 0, 1'b0, 1'b0);
      lit("conflict_hit_blk5", last_blk, 5);
      lit("conflict_hit", last_hit, 1);

      // req_i held through a miss, then stray fill_done_i while idle.
      r0 = resp_cnt;
      access(16'h0314, 1, 2, 0, 1'b1, 1'b0);
      idle(1, 1'b0);
      lit("held_req_one_response", resp_cnt - r0, 1);
      access(16'h0114, 0, 0, 0, 1'b0, 1'b0);
      idle(2, 1'b1);
      access(16'h0314, 0, 0, 0, 1'b0, 1'b0);
      lit("stray_fill_no_write", last_hit, 1);
      lit("stray_fill_blk", last_blk, 1);

      // Reset in the middle of FILL.
      r0 = resp_cnt;
      access(16'h0414, 5, 3, 0, 1'b0, 1'b1);
      lit("reset_no_response", resp_cnt - r0, 0);
      idle(1, 1'b0);
      access(16'h0314, 1, 0, 0, 1'b0, 1'b0);
      lit("reset_cleared_tags", last_hit, 0);
      idle(1, 1'b0);

      // Fully associative configuration.
      sel = 1'b1;
      idle(1, 1'b0);
      access(16'h0000, 0, 0, 0, 1'b0, 1'b0);
      access(16'h0010, 1, 0, 0, 1'b0, 1'b0);
      access(16'h0020, 2, 1, 0, 1'b0, 1'b0);
      access(16'h0030, 3, 0, 0, 1'b0, 1'b0);
      access(16'h0040, 0, 0, 0, 1'b0, 1'b0);
      access(16'h0000, 1, 0, 0, 1'b0, 1'b0);
      lit("fa_first_evicted", last_hit, 0);
      access(16'h0040, 0, 0, 0, 1'b0, 1'b0);
      lit("fa_fifth_hit", last_hit, 1);
      lit("fa_fifth_blk", last_blk, 0);
      idle(2, 1'b0);

      @(negedge clock);
      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
